// File: rtl/board_read_scheduler_pkg.sv
// Shared definitions for the board BRAM read scheduler: memory geometry,
// scheduler state encodings and the response tag layout.
package board_read_scheduler_pkg;

   localparam int unsigned WORD_SIZE    = 16;
   localparam int unsigned LOG_MAX_ADDR = 12;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t S_IDLE = 2'd0;
   localparam sched_state_t S_WAIT = 2'd1;
   localparam sched_state_t S_BUSY = 2'd2;
   localparam sched_state_t S_SWAP = 2'd3;

   localparam logic OWNER_RND = 1'b0;
   localparam logic OWNER_UPD = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } read_tag_t;

   // A period of 0 behaves like 1: every frame boundary may start a generation.
   function automatic logic period_reached(input logic [7:0] frame_cnt,
                                           input logic [7:0] gen_period);
      logic [8:0] next_cnt;
      logic [8:0] limit;
      next_cnt = {1'b0, frame_cnt} + 9'd1;
      limit    = (gen_period == 8'd0) ? 9'd1 : {1'b0, gen_period};
      return next_cnt >= limit;
   endfunction

endpackage

// File: rtl/board_read_scheduler_read_tag_pipe.sv
// Fixed-depth shift register that tracks which requester owns each read in
// flight so the returning BRAM word can be steered to the right valid strobe.
module read_tag_pipe
   import board_read_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH = 3
)(
   input  logic      clk,
   input  logic      rst_n,
   input  read_tag_t req_tag,
   output read_tag_t rsp_tag
);

   read_tag_t stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= req_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign rsp_tag = stage[DEPTH-1];

endmodule

// File: rtl/board_read_scheduler.sv
// Arbitrates the board BRAM read port between renderer and update engine and
// paces update generations to display frame boundaries.
module board_read_scheduler
   import board_read_scheduler_pkg::*;
#(
   parameter int unsigned WORD_SIZE    = board_read_scheduler_pkg::WORD_SIZE,
   parameter int unsigned LOG_MAX_ADDR = board_read_scheduler_pkg::LOG_MAX_ADDR,
   parameter int unsigned READ_LATENCY = 2
)(
   input  logic                    clk_130mhz,
   input  logic                    rst_n_in,
   input  logic                    rnd_req_in,
   input  logic [LOG_MAX_ADDR-1:0] rnd_addr_in,
   output logic                    rnd_valid_out,
   output logic [WORD_SIZE-1:0]    rnd_data_out,
   input  logic                    upd_req_in,
   input  logic [LOG_MAX_ADDR-1:0] upd_addr_in,
   output logic                    upd_gnt_out,
   output logic                    upd_valid_out,
   output logic [WORD_SIZE-1:0]    upd_data_out,
   output logic [LOG_MAX_ADDR-1:0] addr_r_out,
   input  logic [WORD_SIZE-1:0]    data_r_in,
   input  logic                    frame_done_in,
   input  logic                    run_in,
   input  logic                    step_in,
   input  logic [7:0]              gen_period_in,
   output logic                    upd_start_out,
   input  logic                    upd_done_in,
   output logic                    swap_out,
   output logic [15:0]             stall_cnt_out
);

   read_tag_t    issue_tag;
   read_tag_t    ret_tag;
   sched_state_t state;
   sched_state_t state_nx;
   logic [7:0]   frame_cnt;
   logic [7:0]   frame_cnt_nx;
   logic         single_step;
   logic         single_step_nx;

   // ---------------- read port arbitration ----------------
   assign upd_gnt_out = upd_req_in & ~rnd_req_in;

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         addr_r_out <= '0;
      end else if (rnd_req_in) begin
         addr_r_out <= rnd_addr_in;
      end else if (upd_gnt_out) begin
         addr_r_out <= upd_addr_in;
      end
   end

   always_comb begin
      issue_tag.valid = rnd_req_in | upd_gnt_out;
      issue_tag.owner = rnd_req_in ? OWNER_RND : OWNER_UPD;
   end

   // One stage for the address register plus the BRAM read latency.
   read_tag_pipe #(
      .DEPTH(1 + READ_LATENCY)
   ) u_tag_pipe (
      .clk    (clk_130mhz),
      .rst_n  (rst_n_in),
      .req_tag(issue_tag),
      .rsp_tag(ret_tag)
   );

   assign rnd_valid_out = ret_tag.valid & (ret_tag.owner == OWNER_RND);
   assign upd_valid_out = ret_tag.valid & (ret_tag.owner == OWNER_UPD);
   assign rnd_data_out  = data_r_in;
   assign upd_data_out  = data_r_in;

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stall_cnt_out <= '0;
      end else if (upd_req_in && rnd_req_in && (stall_cnt_out != 16'hFFFF)) begin
         stall_cnt_out <= stall_cnt_out + 16'd1;
      end
   end

   // ---------------- generation pacing ----------------
   always_comb begin
      state_nx       = state;
      frame_cnt_nx   = frame_cnt;
      single_step_nx = single_step;
      upd_start_out  = 1'b0;
      swap_out       = 1'b0;
      case (state)
         S_IDLE: begin
            if (run_in || step_in) begin
               state_nx       = S_WAIT;
               frame_cnt_nx   = '0;
               single_step_nx = step_in & ~run_in;
            end
         end
         S_WAIT: begin
            if (!run_in && !single_step) begin
               state_nx = S_IDLE;
            end else if (frame_done_in) begin
               if (period_reached(frame_cnt, gen_period_in)) begin
                  upd_start_out = 1'b1;
                  state_nx      = S_BUSY;
                  frame_cnt_nx  = '0;
               end else begin
                  frame_cnt_nx = frame_cnt + 8'd1;
               end
            end
         end
         S_BUSY: begin
            // A coincident frame boundary is deliberately not used for the swap.
            if (upd_done_in) begin
               state_nx = S_SWAP;
            end
         end
         S_SWAP: begin
            if (frame_done_in) begin
               swap_out = 1'b1;
               if (run_in && !single_step) begin
                  state_nx     = S_WAIT;
                  frame_cnt_nx = '0;
               end else begin
                  state_nx       = S_IDLE;
                  single_step_nx = 1'b0;
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= S_IDLE;
         frame_cnt   <= '0;
         single_step <= 1'b0;
      end else begin
         state       <= state_nx;
         frame_cnt   <= frame_cnt_nx;
         single_step <= single_step_nx;
      end
   end

endmodule

// File: tb/tb_board_read_scheduler.sv
// Directed bench for board_read_scheduler with a two-cycle BRAM model.
module tb_board_read_scheduler;
   import board_read_scheduler_pkg::*;

   localparam int unsigned W = WORD_SIZE;
   localparam int unsigned A = LOG_MAX_ADDR;

   logic         clk_130mhz = 1'b0;
   logic         rst_n_in;
   logic         rnd_req_in;
   logic [A-1:0] rnd_addr_in;
   logic         rnd_valid_out;
   logic [W-1:0] rnd_data_out;
   logic         upd_req_in;
   logic [A-1:0] upd_addr_in;
   logic         upd_gnt_out;
   logic         upd_valid_out;
   logic [W-1:0] upd_data_out;
   logic [A-1:0] addr_r_out;
   logic [W-1:0] data_r_in;
   logic         frame_done_in;
   logic         run_in;
   logic         step_in;
   logic [7:0]   gen_period_in;
   logic         upd_start_out;
   logic         upd_done_in;
   logic         swap_out;
   logic [15:0]  stall_cnt_out;

   logic [W-1:0] bram_p1;
   logic         st;
   logic         sw;

   int errors = 0;
   int checks = 0;

   board_read_scheduler #(
      .READ_LATENCY(2)
   ) dut (
      .clk_130mhz   (clk_130mhz),
      .rst_n_in     (rst_n_in),
      .rnd_req_in   (rnd_req_in),
      .rnd_addr_in  (rnd_addr_in),
      .rnd_valid_out(rnd_valid_out),
      .rnd_data_out (rnd_data_out),
      .upd_req_in   (upd_req_in),
      .upd_addr_in  (upd_addr_in),
      .upd_gnt_out  (upd_gnt_out),
      .upd_valid_out(upd_valid_out),
      .upd_data_out (upd_data_out),
      .addr_r_out   (addr_r_out),
      .data_r_in    (data_r_in),
      .frame_done_in(frame_done_in),
      .run_in       (run_in),
      .step_in      (step_in),
      .gen_period_in(gen_period_in),
      .upd_start_out(upd_start_out),
      .upd_done_in  (upd_done_in),
      .swap_out     (swap_out),
      .stall_cnt_out(stall_cnt_out)
   );

   always #4 clk_130mhz = ~clk_130mhz;

   // BRAM content: word(a) = a ^ 16'hA5C0, two cycles after the address changes.
   always @(posedge clk_130mhz) begin
      bram_p1   <= W'(addr_r_out) ^ W'(16'hA5C0);
      data_r_in <= bram_p1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_130mhz);
      #1;
   endtask

   task automatic do_reset();
      rst_n_in      = 1'b0;
      rnd_req_in    = 1'b0;
      rnd_addr_in   = '0;
      upd_req_in    = 1'b0;
      upd_addr_in   = '0;
      frame_done_in = 1'b0;
      run_in        = 1'b0;
      step_in       = 1'b0;
      gen_period_in = '0;
      upd_done_in   = 1'b0;
      cyc();
      cyc();
      rst_n_in = 1'b1;
      cyc();
   endtask

   task automatic frame(output logic start_seen, output logic swap_seen);
      frame_done_in = 1'b1;
      #1;
      start_seen = upd_start_out;
      swap_seen  = swap_out;
      cyc();
      frame_done_in = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic done(output logic swap_seen);
      upd_done_in = 1'b1;
      #1;
      swap_seen = swap_out;
      cyc();
      upd_done_in = 1'b0;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [A-1:0] exp_addr [7];
      logic         exp_rv   [7];
      logic [W-1:0] exp_rd   [7];
      exp_addr = '{12'd5, 12'd6, 12'd7, 12'd7, 12'd7, 12'd7, 12'd7};
      exp_rv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_rd   = '{16'h0, 16'h0, 16'hA5C5, 16'hA5C6, 16'hA5C7, 16'h0, 16'h0};

      // Reset state
      rst_n_in      = 1'b0;
      rnd_req_in    = 1'b0;
      rnd_addr_in   = '0;
      upd_req_in    = 1'b0;
      upd_addr_in   = '0;
      frame_done_in = 1'b0;
      run_in        = 1'b0;
      step_in       = 1'b0;
      gen_period_in = '0;
      upd_done_in   = 1'b0;
      #1;
      check_eq("rst_addr", addr_r_out, 0);
      check_eq("rst_rvalid", rnd_valid_out, 0);
      check_eq("rst_uvalid", upd_valid_out, 0);
      check_eq("rst_stall", stall_cnt_out, 0);
      check_eq("rst_start", upd_start_out, 0);
      check_eq("rst_swap", swap_out, 0);
      check_eq("rst_gnt", upd_gnt_out, 0);

      // 1: renderer reads 5,6,7 back to back
      do_reset();
      rnd_req_in  = 1'b1;
      rnd_addr_in = 12'd5;
      for (int i = 0; i < 7; i++) begin
         cyc();
         #1;
         check_eq("t1_addr", addr_r_out, exp_addr[i]);
         check_eq("t1_rvalid", rnd_valid_out, exp_rv[i]);
         if (exp_rv[i]) check_eq("t1_rdata", rnd_data_out, exp_rd[i]);
         check_eq("t1_uvalid", upd_valid_out, 0);
         if (i == 0) rnd_addr_in = 12'd6;
         if (i == 1) rnd_addr_in = 12'd7;
         if (i == 2) rnd_req_in = 1'b0;
      end

      // 2: update request stalled by renderer for 4 cycles
      do_reset();
      for (int c = 0; c < 9; c++) begin
         rnd_req_in  = (c < 4);
         rnd_addr_in = 12'd100;
         upd_req_in  = (c <= 4);
         upd_addr_in = 12'd42;
         #1;
         if (c <= 4) check_eq("t2_gnt", upd_gnt_out, (c == 4));
         check_eq("t2_uvalid", upd_valid_out, (c == 7));
         if (c == 7) check_eq("t2_udata", upd_data_out, 16'hA5EA);
         check_eq("t2_rvalid", rnd_valid_out, (c >= 3 && c <= 6));
         if (c == 3) check_eq("t2_rdata", rnd_data_out, 16'hA5A4);
         if (c == 5) check_eq("t2_addr", addr_r_out, 42);
         cyc();
      end
      check_eq("t2_stall", stall_cnt_out, 4);

      // 3: run with period 3, swap waits for frame boundary
      do_reset();
      gen_period_in = 8'd3;
      run_in        = 1'b1;
      cyc();
      frame(st, sw); check_eq("t3_f1_start", st, 0);
      frame(st, sw); check_eq("t3_f2_start", st, 0);
      frame(st, sw); check_eq("t3_f3_start", st, 1);
      done(sw);      check_eq("t3_done_swap", sw, 0);
      #1;
      check_eq("t3_noearly_swap", swap_out, 0);
      frame(st, sw); check_eq("t3_swap", sw, 1);
      check_eq("t3_swap_nostart", st, 0);
      frame(st, sw); check_eq("t3_g2_f1", st, 0);
      frame(st, sw); check_eq("t3_g2_f2", st, 0);
      frame(st, sw); check_eq("t3_g2_f3", st, 1);
      frame_done_in = 1'b1;
      upd_done_in   = 1'b1;
      #1;
      check_eq("t3_coinc_swap", swap_out, 0);
      cyc();
      frame_done_in = 1'b0;
      upd_done_in   = 1'b0;
      cyc();
      frame(st, sw); check_eq("t3_coinc_next_swap", sw, 1);

      // 4: period 0 starts on the first frame; run dropped while busy
      do_reset();
      gen_period_in = 8'd0;
      run_in        = 1'b1;
      cyc();
      frame(st, sw); check_eq("t4_start1", st, 1);
      done(sw);
      frame(st, sw); check_eq("t4_swap1", sw, 1);
      frame(st, sw); check_eq("t4_start2", st, 1);
      run_in = 1'b0;
      done(sw);
      frame(st, sw); check_eq("t4_swap_after_drop", sw, 1);
      frame(st, sw); check_eq("t4_idle_nostart", st, 0);

      // 5: single step, extra step in busy ignored
      do_reset();
      gen_period_in = 8'd2;
      step_in       = 1'b1;
      cyc();
      step_in = 1'b0;
      frame(st, sw); check_eq("t5_f1_start", st, 0);
      frame(st, sw); check_eq("t5_f2_start", st, 1);
      step_in = 1'b1;
      cyc();
      step_in = 1'b0;
      done(sw);
      frame(st, sw); check_eq("t5_swap", sw, 1);
      frame(st, sw); check_eq("t5_idle_f1", st, 0);
      frame(st, sw); check_eq("t5_idle_f2", st, 0);
      frame(st, sw); check_eq("t5_idle_f3_start", st, 0);
      check_eq("t5_idle_f3_swap", sw, 0);

      // 6: reset with reads in flight
      do_reset();
      rnd_req_in  = 1'b1;
      rnd_addr_in = 12'd9;
      upd_req_in  = 1'b1;
      upd_addr_in = 12'd50;
      cyc();
      rnd_addr_in = 12'd10;
      cyc();
      #1;
      check_eq("t6_stall_pre", stall_cnt_out, 2);
      rst_n_in   = 1'b0;
      rnd_req_in = 1'b0;
      upd_req_in = 1'b0;
      #1;
      check_eq("t6_rst_addr", addr_r_out, 0);
      check_eq("t6_rst_rvalid", rnd_valid_out, 0);
      check_eq("t6_rst_stall", stall_cnt_out, 0);
      cyc();
      cyc();
      rst_n_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check_eq("t6_no_valid", {rnd_valid_out, upd_valid_out}, 0);
         cyc();
      end
      frame(st, sw); check_eq("t6_idle_nostart", st, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_read_scheduler.md
Name: board_read_scheduler

Overview:
- Shares the single read port of the board BRAM between two requesters:
  - the renderer fetch path (hard real-time, absolute priority);
  - the life update engine (best-effort).
- Paces generations to the display frame rate:
  - starts the update engine at a frame boundary;
  - withholds the buffer swap until the next frame boundary, so no frame mixes two generations.
- Sits between renderer, update engine and board memory in the top level.

Parameters:
- WORD_SIZE, package default, BRAM word width.
- LOG_MAX_ADDR, package default, BRAM address width.
- READ_LATENCY, 2, cycles from addr_r_out change to valid data_r_in.

Ports:
- clk_130mhz  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rnd_req_in  in  1  renderer read request this cycle
- rnd_addr_in  in  LOG_MAX_ADDR  renderer address
- rnd_valid_out  out  1  renderer data valid
- rnd_data_out  out  WORD_SIZE  renderer read data
- upd_req_in  in  1  update engine request, held until granted
- upd_addr_in  in  LOG_MAX_ADDR  update address, stable while upd_req_in is high
- upd_gnt_out  out  1  update request accepted this cycle
- upd_valid_out  out  1  update data valid
- upd_data_out  out  WORD_SIZE  update read data
- addr_r_out  out  LOG_MAX_ADDR  BRAM read address
- data_r_in  in  WORD_SIZE  BRAM read data
- frame_done_in  in  1  one-cycle pulse at end of each displayed frame
- run_in  in  1  continuous simulation enable
- step_in  in  1  single-generation pulse
- gen_period_in  in  8  frames per generation
- upd_start_out  out  1  one-cycle pulse that starts the update engine
- upd_done_in  in  1  one-cycle pulse when the engine has finished writing
- swap_out  out  1  one-cycle pulse that swaps the front/back board buffers
- stall_cnt_out  out  16  saturating count of cycles upd_req_in was refused

Behaviour:

Reset values:
- All outputs 0; FSM in S_IDLE; frame counter 0; tag pipe cleared.

Arbitration (per cycle):
- Renderer always wins.
- upd_gnt_out = upd_req_in & ~rnd_req_in. It is combinational and asserts in the cycle the request is accepted.

Address path:
- addr_r_out is registered.
- On the edge after the request cycle it takes rnd_addr_in if rnd_req_in, else upd_addr_in if granted, else it holds its value.

Response tagging:
- A tag shift register, depth 1+READ_LATENCY, carries {valid, owner}.
- rnd_valid_out / upd_valid_out are driven from the tag pipe tail.
- Latency is exactly 1+READ_LATENCY cycles (3 by default) from request cycle to valid cycle.
- rnd_data_out = upd_data_out = data_r_in (combinational). Consumers qualify with their own valid.
- Back-to-back requests are fully pipelined: one per cycle, returned in order.

stall_cnt_out:
- Increments when upd_req_in & rnd_req_in.
- Saturates at 16'hFFFF.
- Cleared only by reset.

Scheduler FSM:
- S_IDLE:
  - run_in | step_in → S_WAIT; frame counter := 0.
- S_WAIT:
  - Each frame_done_in increments the frame counter.
  - When the counter + 1 ≥ max(gen_period_in, 1) on a frame_done_in: go to S_BUSY, pulse upd_start_out that same cycle, counter := 0.
  - If run_in = 0 and this state was not entered via step_in → S_IDLE.
  - A latched single_step flag records step entry.
- S_BUSY:
  - upd_done_in → S_SWAP.
  - frame_done_in is ignored; not counted.
- S_SWAP:
  - On the next frame_done_in: pulse swap_out.
  - Then go to S_WAIT if run_in & ~single_step; otherwise to S_IDLE and clear single_step.

Boundary conditions:
- upd_done_in and frame_done_in in the same cycle in S_BUSY: go to S_SWAP only; the swap waits for the following frame.
- step_in while in S_WAIT/S_BUSY/S_SWAP: ignored.
- Dropping run_in in S_BUSY: the generation completes and swaps, then returns to S_IDLE.
- Asynchronous reset mid-read: in-flight tags are discarded; no valid pulses follow reset release.

Decomposition:
- Shared package holds WORD_SIZE, LOG_MAX_ADDR and a new typedef sched_state_t (S_IDLE, S_WAIT, S_BUSY, S_SWAP).
- One natural sub-module: read_tag_pipe (parameterised depth, carries {valid, owner}).

Test Plan:
1. Renderer-only requests at addrs 5, 6, 7 on consecutive cycles → addr_r_out 5, 6, 7 one cycle later; rnd_valid_out high 3 cycles after each request with the matching BRAM model words; upd_valid_out stays 0.
2. upd_req_in held with addr 42 while rnd_req_in is high for 4 cycles, then low → upd_gnt_out is 0 for 4 cycles then 1; upd_valid_out 3 cycles after grant carries word 42; stall_cnt_out = 4.
3. run_in = 1, gen_period_in = 3 → upd_start_out pulses on the 3rd frame_done_in; upd_done_in mid-frame → swap_out on the next frame_done_in, not earlier.
4. gen_period_in = 0 → start on every first frame_done_in after entering S_WAIT.
5. step_in pulse with run_in = 0 → exactly one upd_start_out / swap_out pair, then S_IDLE; a second step_in during S_BUSY produces no extra generation.
6. Assert rst_n_in low with 2 reads in flight → all outputs 0 immediately; no valid pulses after release; FSM in S_IDLE.
